// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver for the keypad link: synchronises the line, assembles a byte,
// holds it in a one-deep buffer and decodes keypad ASCII back to the 4-bit key code.
module uart_rx_decoder #(
  parameter int CLKS_PER_BIT = 2812,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          sync1_q, rx_s_q;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          commit;
  logic          stop_bad;
  logic          key_hit;

  // Handshake: rx_valid stays high until a cycle with rx_ack high; a byte that
  // completes while rx_valid is high and unacknowledged is dropped and flags overrun.

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    commit   = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE at the stop mid-point lets a back-to-back start edge be caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = stop_bad;
    if (commit) begin
      if (!valid_q || rx_ack) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_comb begin
    key_code = 4'h0;
    key_hit  = 1'b1;
    case (data_q) inside
      [8'h30:8'h39]: key_code = data_q[3:0];
      [8'h41:8'h44]: key_code = data_q[3:0] + 4'd9;
      8'h2A:         key_code = 4'hF;
      8'h23:         key_code = 4'hE;
      default:       key_hit  = 1'b0;
    endcase
    if (!(valid_q && key_hit)) key_code = 4'h0;
  end

  assign key_valid = valid_q && key_hit;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Bench for uart_rx_decoder: drives 8N1 frames cycle by cycle and checks every output
// each cycle against a frame-level model of the receive buffer and keypad decode.
module tb_uart_rx_decoder;

  localparam int CPB      = 16;
  localparam int HALF     = CPB / 2;
  localparam int FRAME_N  = 10 * CPB;
  // Edge (1-based from the first cycle the start bit is driven) at which the stop bit is
  // sampled: two synchroniser flops, one IDLE detect cycle, half a bit, nine full bits.
  localparam int COMMIT_N = 3 + HALF + 9 * CPB;
  localparam int EV_NONE  = 0;
  localparam int EV_GOOD  = 1;
  localparam int EV_BAD   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] key_code;
  logic       key_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int   n_vec  = 0;
  int   n_err  = 0;
  int   fe_cnt = 0;
  logic chk_on = 1'b0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  logic       m_ferr;

  uart_rx_decoder #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] key_char(input int c);
    if (c < 10) return 8'h30 + 8'(c);
    if (c < 14) return 8'h41 + 8'(c - 10);
    if (c == 14) return 8'h23;
    return 8'h2A;
  endfunction

  // {key_valid, key_code} by searching the keypad character table.
  function automatic logic [4:0] model_key(input logic v, input logic [7:0] b);
    logic [4:0] r;
    r = 5'h00;
    if (v) begin
      for (int c = 0; c < 16; c++) begin
        if (key_char(c) == b) r = {1'b1, 4'(c)};
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (chk_on) begin
      chk("rx_valid", 16'(rx_valid), 16'(m_valid));
      chk("rx_data", 16'(rx_data), 16'(m_data));
      chk("overrun", 16'(overrun), 16'(m_ovr));
      chk("frame_err", 16'(frame_err), 16'(m_ferr));
      chk("key", 16'({key_valid, key_code}), 16'(model_key(m_valid, m_data)));
    end
  end

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // One clock cycle: drive the line and ack, then apply what that edge means to the buffer.
  task automatic tick(input logic line, input logic ack, input int ev, input logic [7:0] b);
    @(negedge clk);
    uart_rx = line;
    rx_ack  = ack;
    @(posedge clk);
    m_ferr = 1'b0;
    if (ev == EV_GOOD && (!m_valid || ack)) begin
      m_data  = b;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
    end else if (ev == EV_GOOD) begin
      m_ovr = 1'b1;
    end else begin
      if (ev == EV_BAD) m_ferr = 1'b1;
      if (ack && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input int ack_at);
    for (int i = 1; i <= n; i++) tick(1'b1, i == ack_at, EV_NONE, 8'h00);
  endtask

  task automatic low_hold(input int n);
    for (int i = 1; i <= n; i++) tick(1'b0, 1'b0, EV_NONE, 8'h00);
  endtask

  task automatic mid_reset();
    #2;
    rst     = 1'b0;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    model_reset();
    #1;
    chk("reset_async", {rx_data, rx_valid, key_code, key_valid, frame_err, overrun}, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                            input int rst_at);
    int   bi;
    logic line;
    for (int n = 1; n <= FRAME_N; n++) begin
      bi = (n - 1) / CPB;
      if (bi == 0)      line = 1'b0;
      else if (bi == 9) line = stop;
      else              line = b[bi-1];
      if (n == rst_at) begin
        mid_reset();
        return;
      end
      tick(line, n == ack_at, (n == COMMIT_N) ? (stop ? EV_GOOD : EV_BAD) : EV_NONE, b);
    end
  endtask

  initial begin
    int         fe0;
    int         op;
    int         ack_at;
    int         r;
    logic [7:0] b;

    rst     = 1'b0;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {rx_data, rx_valid, key_code, key_valid, frame_err, overrun}, 16'h0000);
    @(negedge clk);
    rst    = 1'b1;
    chk_on = 1'b1;
    idle(4, 0);

    // Single keypad digit, then acknowledge.
    send_frame(8'h35, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t1_data", 16'(rx_data), 16'h0035);
    chk("t1_key", 16'({key_valid, key_code}), 16'h0015);
    idle(3, 1);
    #1;
    chk("t1_ack", 16'(rx_valid), 16'h0000);

    // '*', '#', then a non-keypad byte.
    send_frame(8'h2A, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t2_star", 16'({key_valid, key_code}), 16'h001F);
    idle(3, 1);
    send_frame(8'h23, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t2_hash", 16'({key_valid, key_code}), 16'h001E);
    idle(3, 1);
    send_frame(8'h7A, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t2_z_valid", 16'(rx_valid), 16'h0001);
    chk("t2_z_key", 16'({key_valid, key_code}), 16'h0000);
    idle(3, 1);

    // Short low glitch on an idle line.
    fe0 = fe_cnt;
    low_hold(HALF - 3);
    idle(HALF + 20, 0);
    #1;
    chk("t3_valid", 16'(rx_valid), 16'h0000);
    chk("t3_ferr", 16'(fe_cnt - fe0), 16'h0000);

    // Bad stop bit followed by a held-low line, then a good 'B'.
    fe0 = fe_cnt;
    send_frame(8'h41, 1'b0, 0, 0);
    low_hold(300);
    #1;
    chk("t4_ferr_pulses", 16'(fe_cnt - fe0), 16'h0001);
    chk("t4_valid", 16'(rx_valid), 16'h0000);
    idle(8, 0);
    send_frame(8'h42, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t4_key_b", 16'({key_valid, key_code}), 16'h001B);
    idle(3, 1);

    // Back-to-back frames without ack, then with ack on the second commit edge.
    send_frame(8'h31, 1'b1, 0, 0);
    send_frame(8'h32, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t5_keep_first", 16'(rx_data), 16'h0031);
    chk("t5_overrun", 16'(overrun), 16'h0001);
    idle(3, 1);
    #1;
    chk("t5_ack_clear", 16'({rx_valid, overrun}), 16'h0000);
    send_frame(8'h31, 1'b1, 0, 0);
    send_frame(8'h32, 1'b1, COMMIT_N, 0);
    idle(3, 0);
    #1;
    chk("t5_ack_commit_data", 16'(rx_data), 16'h0032);
    chk("t5_ack_commit_ovr", 16'({rx_valid, overrun}), 16'h0002);

    // Reset in the middle of data bit 4, then a clean 'D'.
    send_frame(8'h99, 1'b1, 0, 3 + HALF + 4 * CPB + CPB / 2);
    idle(10, 0);
    send_frame(8'h44, 1'b1, 0, 0);
    idle(3, 0);
    #1;
    chk("t6_data", 16'(rx_data), 16'h0044);
    chk("t6_key", 16'({key_valid, key_code}), 16'h001D);
    idle(3, 1);

    // Random mix of frames, errors, glitches and acks.
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) b = key_char($urandom_range(0, 15));
      else                           b = 8'($urandom);
      r = $urandom_range(0, 5);
      if (r == 0)      ack_at = COMMIT_N;
      else if (r == 1) ack_at = $urandom_range(1, FRAME_N);
      else             ack_at = 0;
      if (op <= 5) begin
        send_frame(b, 1'b1, ack_at, 0);
        idle($urandom_range(0, 12), $urandom_range(0, 12));
      end else if (op == 6) begin
        send_frame(b, 1'b0, ack_at, 0);
        low_hold($urandom_range(1, 40));
        idle($urandom_range(4, 12), $urandom_range(0, 12));
      end else if (op == 7) begin
        low_hold($urandom_range(1, HALF - 2));
        idle($urandom_range(HALF + 4, 24), $urandom_range(0, 24));
      end else if (op == 8) begin
        idle($urandom_range(1, 20), $urandom_range(1, 20));
      end else begin
        send_frame(b, 1'b1, 0, 0);
        send_frame(~b, 1'b1, ack_at, 0);
      end
    end

    idle(5, 0);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
